// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for uart_receiver: FSM states, baud select encoding, divisor math.
// The PARITY state exists only when UART_RECEIVER_PARITY_EN is defined.
package uart_receiver_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RECEIVER_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // Clock cycles per oversample tick; never below 1 so the tick counter stays meaningful.
  function automatic int unsigned baud_divisor(input int unsigned clockHz, input baud_sel_e sel);
    int unsigned baud;
    int unsigned div;
    case (sel)
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      BAUD_57600: baud = 57600;
      default:    baud = 115200;
    endcase
    div = clockHz / (baud * OVERSAMPLE);
    if (div == 0) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_receiver_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned   PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_ff @(posedge clock_i) begin
    if (doPush) mem_q[wrPtr_q] <= push_data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampling UART receiver (8N1, or 8E1 with UART_RECEIVER_PARITY_EN) feeding a FWFT byte FIFO.
// Line synchronizer, baud tick generator and deframing FSM live here; storage is uart_receiver_fifo.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 50_000_000,
  parameter int unsigned BUFFER_DEPTH  = 16
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  input  logic       data_read_i,
  output logic [7:0] data_o,
  output logic       data_buffer_empty_o,
  output logic       data_buffer_full_o,
  output logic       overrun_error_o,
`ifdef UART_RECEIVER_PARITY_EN
  output logic       parity_error_o,
`endif
  output logic       frame_error_o
);

  localparam int unsigned DIV_9600   = baud_divisor(CLOCK_FREQ_HZ, BAUD_9600);
  localparam int unsigned DIV_19200  = baud_divisor(CLOCK_FREQ_HZ, BAUD_19200);
  localparam int unsigned DIV_57600  = baud_divisor(CLOCK_FREQ_HZ, BAUD_57600);
  localparam int unsigned DIV_115200 = baud_divisor(CLOCK_FREQ_HZ, BAUD_115200);
  localparam int unsigned DIV_W      = $clog2(DIV_9600 + 1);
  localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]  MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
`ifdef UART_RECEIVER_PARITY_EN
  localparam rx_state_e   AFTER_DATA  = ST_PARITY;
`else
  localparam rx_state_e   AFTER_DATA  = ST_STOP;
`endif

  logic             sync1_q, sync2_q, prev_q;
  logic             fallEdge;
  rx_state_e        state_q;
  baud_sel_e        baudSel_q;
  logic [DIV_W-1:0] divCnt_q, divCnt_d, divMax;
  logic             tick;
  logic [3:0]       sampleCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             frameErr_q;
  logic             overrun_q;
  logic             parityOk;
  logic             push;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fallEdge = prev_q && !sync2_q;

  always_comb begin
    case (baudSel_q)
      BAUD_9600:  divMax = DIV_W'(DIV_9600 - 1);
      BAUD_19200: divMax = DIV_W'(DIV_19200 - 1);
      BAUD_57600: divMax = DIV_W'(DIV_57600 - 1);
      default:    divMax = DIV_W'(DIV_115200 - 1);
    endcase
  end

  assign tick = (state_q != ST_IDLE) && (divCnt_q == divMax);

  // Held at zero while idle so the first tick of a frame is exactly one divisor after start detect.
  always_comb begin
    divCnt_d = divCnt_q + DIV_W'(1);
    if (state_q == ST_IDLE || tick) divCnt_d = '0;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) divCnt_q <= '0;
    else            divCnt_q <= divCnt_d;
  end

`ifdef UART_RECEIVER_PARITY_EN
  logic parityBad_q;
  logic parityErr_q;
  assign parityOk       = !parityBad_q;
  assign parity_error_o = parityErr_q;
`else
  assign parityOk = 1'b1;
`endif

  assign push = (state_q == ST_STOP) && tick && (sampleCnt_q == LAST_SAMPLE) && sync2_q && parityOk;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      baudSel_q   <= BAUD_9600;
      sampleCnt_q <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      frameErr_q  <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parityBad_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      frameErr_q <= 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
      parityErr_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          baudSel_q   <= baud_sel_e'(baudrate_select_i);
          sampleCnt_q <= '0;
          if (fallEdge) state_q <= ST_START;
        end
        // Mid-bit check of the start bit rejects short glitches silently.
        ST_START: if (tick) begin
          sampleCnt_q <= sampleCnt_q + 4'd1;
          if (sampleCnt_q == MID_SAMPLE) begin
            sampleCnt_q <= '0;
            bitIdx_q    <= '0;
`ifdef UART_RECEIVER_PARITY_EN
            parityBad_q <= 1'b0;
`endif
            state_q     <= sync2_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: if (tick) begin
          sampleCnt_q <= sampleCnt_q + 4'd1;
          if (sampleCnt_q == LAST_SAMPLE) begin
            shift_q  <= {sync2_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) state_q <= AFTER_DATA;
          end
        end
`ifdef UART_RECEIVER_PARITY_EN
        ST_PARITY: if (tick) begin
          sampleCnt_q <= sampleCnt_q + 4'd1;
          if (sampleCnt_q == LAST_SAMPLE) begin
            parityBad_q <= (sync2_q != ^shift_q);
            parityErr_q <= (sync2_q != ^shift_q);
            state_q     <= ST_STOP;
          end
        end
`endif
        ST_STOP: if (tick) begin
          sampleCnt_q <= sampleCnt_q + 4'd1;
          if (sampleCnt_q == LAST_SAMPLE) begin
            if (sync2_q) begin
              state_q <= ST_IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: if (sync2_q) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A full FIFO with a same-cycle pop still takes the byte, so only an unpaired push overruns.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) overrun_q <= 1'b0;
    else            overrun_q <= push && data_buffer_full_o && !data_read_i;
  end

  assign frame_error_o   = frameErr_q;
  assign overrun_error_o = overrun_q;

  uart_receiver_fifo #(
    .DEPTH (BUFFER_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (data_read_i),
    .data_o      (data_o),
    .empty_o     (data_buffer_empty_o),
    .full_o      (data_buffer_full_o)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized traffic against a
// frame-level model that predicts each stop-bit sample cycle from the frame start and divisor.
module tb_uart_receiver;

  localparam int unsigned CLK_HZ = 4_000_000;
  localparam int unsigned DEPTH  = 16;
`ifdef UART_RECEIVER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int STOP_TICKS = 8 + 16 * (FRAME_BITS - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [1:0] baudSel = 2'd3;
  logic       rd = 1'b0;
  logic [7:0] dataOut;
  logic       emptyOut, fullOut, ovrOut, ferrOut;
`ifdef UART_RECEIVER_PARITY_EN
  logic       perrOut;
`endif

  typedef struct {
    int         at;
    logic [7:0] data;
    bit         stopOk;
  } frame_ev_t;

  frame_ev_t  pending[$];
  logic [7:0] modelQ[$];
  int         cycle = 0;
  bit         expOverrun = 1'b0;
  bit         expFrame = 1'b0;
  int         checks = 0;
  int         errors = 0;
  bit         randDone = 1'b0;

  uart_receiver #(
    .CLOCK_FREQ_HZ (CLK_HZ),
    .BUFFER_DEPTH  (DEPTH)
  ) dut (
    .clock_i             (clk),
    .reset_n_i           (rst_n),
    .uart_rx_i           (rx),
    .baudrate_select_i   (baudSel),
    .data_read_i         (rd),
    .data_o              (dataOut),
    .data_buffer_empty_o (emptyOut),
    .data_buffer_full_o  (fullOut),
    .overrun_error_o     (ovrOut),
`ifdef UART_RECEIVER_PARITY_EN
    .parity_error_o      (perrOut),
`endif
    .frame_error_o       (ferrOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cycle);
    end
  endtask

  function automatic int divOf(input logic [1:0] sel);
    int baud;
    case (sel)
      2'd0:    baud = 9600;
      2'd1:    baud = 19200;
      2'd2:    baud = 57600;
      default: baud = 115200;
    endcase
    return int'(CLK_HZ) / (baud * 16);
  endfunction

  // Reference model: the FIFO is a queue; each frame resolves at its predicted stop-sample edge.
  always @(posedge clk) begin
    cycle = cycle + 1;
    expOverrun = 1'b0;
    expFrame   = 1'b0;
    if (!rst_n) begin
      modelQ.delete();
      pending.delete();
    end else begin
      bit         popOk;
      bit         pushEv;
      logic [7:0] pushByte;
      popOk    = rd && (modelQ.size() > 0);
      pushEv   = 1'b0;
      pushByte = 8'h00;
      if (pending.size() > 0 && pending[0].at == cycle) begin
        frame_ev_t ev;
        ev = pending.pop_front();
        if (ev.stopOk) begin
          pushEv   = 1'b1;
          pushByte = ev.data;
        end else begin
          expFrame = 1'b1;
        end
      end
      if (popOk) void'(modelQ.pop_front());
      if (pushEv) begin
        if (modelQ.size() < DEPTH) modelQ.push_back(pushByte);
        else                       expOverrun = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset data_o", dataOut, 32'h0);
      check("reset empty", emptyOut, 32'h1);
      check("reset full", fullOut, 32'h0);
      check("reset overrun", ovrOut, 32'h0);
      check("reset frame_error", ferrOut, 32'h0);
    end else begin
      check("data_o", dataOut, (modelQ.size() > 0) ? modelQ[0] : 8'h00);
      check("empty", emptyOut, modelQ.size() == 0);
      check("full", fullOut, modelQ.size() == DEPTH);
      check("overrun", ovrOut, expOverrun);
      check("frame_error", ferrOut, expFrame);
`ifdef UART_RECEIVER_PARITY_EN
      check("parity_error", perrOut, 32'h0);
`endif
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input logic [1:0] sel,
                               input bit scramble);
    int d;
    d = divOf(sel);
    waitCycles(1);
    baudSel = sel;
    rx = 1'b0;
    pending.push_back('{cycle + 3 + STOP_TICKS * d, b, stopOk});
    waitCycles(16 * d);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (scramble && i == 3) baudSel = 2'($urandom);
      waitCycles(16 * d);
    end
`ifdef UART_RECEIVER_PARITY_EN
    rx = ^b;
    waitCycles(16 * d);
`endif
    rx = stopOk;
    waitCycles(16 * d);
    if (!stopOk) begin
      waitCycles(16 * d);
      rx = 1'b1;
      waitCycles(16 * d);
    end
  endtask

  task automatic popOne();
    rd = 1'b1;
    waitCycles(1);
    rd = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expData, input bit expEmpty);
    check({name, " data"}, dataOut, expData);
    check({name, " empty"}, emptyOut, expEmpty);
  endtask

  initial begin
    waitCycles(5);
    rst_n = 1'b1;
    waitCycles(3);

    applyStimulus(8'hA5, 1'b1, 2'd3, 1'b0);
    waitCycles(2);
    checkOutput("a5 frame", 8'hA5, 1'b0);
    popOne();
    checkOutput("a5 popped", 8'h00, 1'b1);

    applyStimulus(8'h00, 1'b1, 2'd0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 2'd0, 1'b0);
    applyStimulus(8'h55, 1'b1, 2'd0, 1'b0);
    waitCycles(2);
    checkOutput("9600 first", 8'h00, 1'b0);
    popOne();
    checkOutput("9600 second", 8'hFF, 1'b0);
    popOne();
    checkOutput("9600 third", 8'h55, 1'b0);
    popOne();
    checkOutput("9600 drained", 8'h00, 1'b1);

    baudSel = 2'd2;
    waitCycles(4);
    rx = 1'b0;
    waitCycles(4 * divOf(2'd2));
    rx = 1'b1;
    waitCycles(32 * divOf(2'd2));
    checkOutput("glitch", 8'h00, 1'b1);

    applyStimulus(8'h3C, 1'b0, 2'd3, 1'b0);
    checkOutput("bad stop", 8'h00, 1'b1);
    applyStimulus(8'h3C, 1'b1, 2'd3, 1'b0);
    waitCycles(2);
    checkOutput("good 3c", 8'h3C, 1'b0);
    popOne();

    for (int v = 1; v <= 17; v++) applyStimulus(8'(v), 1'b1, 2'd3, 1'b0);
    waitCycles(2);
    check("overrun full", fullOut, 32'h1);
    for (int v = 1; v <= 16; v++) begin
      check("overrun order", dataOut, 32'(v));
      popOne();
    end
    checkOutput("overrun drained", 8'h00, 1'b1);

    baudSel = 2'd3;
    waitCycles(1);
    rx = 1'b0;
    waitCycles(32);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 0);
      waitCycles(32);
    end
    rx = 1'b1;
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);
    applyStimulus(8'h7E, 1'b1, 2'd3, 1'b0);
    waitCycles(2);
    checkOutput("after reset", 8'h7E, 1'b0);
    popOne();
    checkOutput("after reset drained", 8'h00, 1'b1);

    fork
      begin
        for (int n = 0; n < 14; n++) begin
          logic [7:0] b;
          logic [1:0] s;
          bit         ok;
          b  = 8'($urandom);
          s  = 2'($urandom_range(1, 3));
          ok = ($urandom_range(0, 9) != 0);
          applyStimulus(b, ok, s, 1'b1);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          rd = ($urandom_range(0, 299) == 0);
          waitCycles(1);
        end
        rd = 1'b0;
      end
    join

    waitCycles(4);
    for (int n = 0; n < DEPTH + 2; n++) begin
      if (modelQ.size() > 0) popOne();
    end
    waitCycles(2);
    check("final empty", emptyOut, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 200_000);
    $display("[TB] FAIL watchdog actual=timeout required=finish cycle=%0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the existing UART transmitter, sharing its baudrate select encoding and clocking. Oversamples the asynchronous `uart_rx_i` line at 16x the selected baudrate, deframes 8N1 characters, and queues received bytes in an internal FIFO read by the host through a pop handshake. Sits between the chip pad and the host bus logic, with the same single clock domain as the transmitter.

## Interface
- `CLOCK_FREQ_HZ`, 50_000_000, system clock frequency used to derive baud divisors
- `BUFFER_DEPTH`, 16, receive FIFO depth in bytes (power of two, ≥2)
- `clock_i` input 1: system clock, all logic on rising edge
- `reset_n_i` input 1: one clock; reset is asynchronous and active-low
- `uart_rx_i` input 1: serial line, idle high, asynchronous to `clock_i`
- `baudrate_select_i` input 2: 0=9600, 1=19200, 2=57600, 3=115200
- `data_read_i` input 1: pop FIFO head this cycle
- `data_o` output 8: FIFO head byte (first-word fall-through), 0 when empty
- `data_buffer_empty_o` output 1: FIFO holds no bytes
- `data_buffer_full_o` output 1: FIFO holds `BUFFER_DEPTH` bytes
- `overrun_error_o` output 1: one-cycle pulse, complete byte dropped because FIFO full
- `frame_error_o` output 1: one-cycle pulse, stop bit sampled low

## Operation
- `uart_rx_i` passes through a 2-flop synchronizer (reset value 1) before any use.
- Tick generator: divisor DIV = floor(CLOCK_FREQ_HZ / (baud*16)); counter counts 0..DIV-1, emits one-cycle tick at DIV-1. 50 MHz: DIV = 325/162/54/27.
- `baudrate_select_i` is latched only in IDLE; changes mid-frame take effect on the next frame.
- FSM states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: tick counter held at 0; synchronized falling edge (1→0) → START, tick counter restarts.
  - START: after 8 ticks sample line; low → DATA (bit index 0), high → IDLE (glitch rejected, no error).
  - DATA: every 16 ticks sample bit, shift in LSB first; after bit 7 → STOP.
  - STOP: after 16 ticks sample; high → push byte, → IDLE; low → `frame_error_o` pulse, byte discarded, → WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized line high, then IDLE (no start detection on a held-low break).
- FIFO: push on valid stop; pop on `data_read_i` when not empty; pop when empty ignored, no error.
- Push while full and no simultaneous pop: byte dropped, `overrun_error_o` pulses, FIFO contents unchanged.
- Push and pop same cycle: both performed, count unchanged; when full, push accepted.
- Pointers wrap modulo `BUFFER_DEPTH`; count width clog2(BUFFER_DEPTH)+1.

## Timing
- Reset values: `data_o`=0, `data_buffer_empty_o`=1, `data_buffer_full_o`=0, both error outputs 0; FSM IDLE, FIFO empty, counters 0.
- Reset mid-frame aborts the frame, partial byte lost, FIFO cleared.
- Start detection latency: 2 cycles of synchronizer plus 1 cycle edge detect.
- Byte visible on `data_o` and `data_buffer_empty_o` deasserted the cycle after the stop-bit sample tick.
- Pop: `data_o` shows next entry the cycle after `data_read_i`; flags update same edge.
- Error pulses are registered, asserted exactly one cycle, coincident with the stop-bit sample edge +1.

## Configuration
- `UART_RECEIVER_PARITY_EN` defined: frame is 8E1; new PARITY state between DATA and STOP samples even parity bit; mismatch adds output `parity_error_o` (1 bit, reset 0, one-cycle pulse) and discards the byte, then continues to STOP normally.
- Undefined: 8N1 only, no PARITY state, no `parity_error_o` port.

## Structure
- Package `uart_receiver_pkg`: FSM state enum, baudrate select enum (shared encoding with transmitter), oversample constant 16, function computing DIV from CLOCK_FREQ_HZ and select.
- One sub-module `uart_receiver_fifo` (parameterized depth/width, FWFT, full/empty, simultaneous push/pop); synchronizer and tick generator stay inline.

## Test plan
- Reset, 115200 baud, send 0xA5 8N1 → `data_o`=0xA5, empty=0 after frame, no error pulses.
- Send 0x00, 0xFF, 0x55 back-to-back at 9600 → three pops return 0x00, 0xFF, 0x55 in order, then empty=1.
- 0.25-bit low glitch on idle line at 57600 → no byte, no errors, FSM back to IDLE.
- Send 0x3C with stop bit held low → `frame_error_o` one pulse, FIFO stays empty; next 0x3C received correctly once line returns high.
- Send 17 bytes 0x01..0x11 without reads (depth 16) → full=1, one `overrun_error_o` pulse, pops return 0x01..0x10.
- Assert `reset_n_i` low mid-DATA of 0x81, release, send 0x7E → only 0x7E in FIFO.
